// File: rtl/adder_arbiter_if.sv
// Request/result handshake bundle for adder_arbiter.
// res_carry exists only when ADDER_ARB_CARRY_EN is defined.
interface adder_arbiter_if #(
  parameter int WIDTH = 16
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_ready;
  logic             res_valid;
  logic [WIDTH-1:0] res_data;
  logic             res_id;
  logic             res_ready;
`ifdef ADDER_ARB_CARRY_EN
  logic             res_carry;
`endif

  modport master (
    output req0_valid, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_a, req1_b,
    input  req1_ready,
    input  res_valid, res_data, res_id,
`ifdef ADDER_ARB_CARRY_EN
    input  res_carry,
`endif
    output res_ready
  );

  modport slave (
    input  req0_valid, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_a, req1_b,
    output req1_ready,
    output res_valid, res_data, res_id,
`ifdef ADDER_ARB_CARRY_EN
    output res_carry,
`endif
    input  res_ready
  );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin share of one address adder between PC-increment and branch ports.
// Define ADDER_ARB_CARRY_EN to widen the add and expose res_carry.
module adder_arbiter #(
  parameter bit FIXED_PRI = 1'b0,
  parameter int WIDTH     = 16
) (
  input logic           clk,
  input logic           rst_n,
  adder_arbiter_if.slave bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           r_state;
  logic             r_ptr;
  logic [WIDTH-1:0] r_data;
  logic             r_id;

  logic             w_can_accept;
  logic             w_pick1;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_gnt;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;

  assign w_can_accept = (r_state == EMPTY) | bus.res_ready;
  assign w_pick1      = FIXED_PRI ? 1'b1 : r_ptr;

  // rst_n gates the grants so readys drop with reset, not on an edge
  assign w_gnt0 = rst_n & w_can_accept & bus.req0_valid
                & (~bus.req1_valid | ~w_pick1);
  assign w_gnt1 = rst_n & w_can_accept & bus.req1_valid
                & (~bus.req0_valid | w_pick1);
  assign w_gnt  = w_gnt0 | w_gnt1;

  assign bus.req0_ready = w_gnt0;
  assign bus.req1_ready = w_gnt1;

  assign w_a = w_gnt1 ? bus.req1_a : bus.req0_a;
  assign w_b = w_gnt1 ? bus.req1_b : bus.req0_b;

`ifdef ADDER_ARB_CARRY_EN
  logic [WIDTH:0] w_sum;
  logic           r_carry;

  assign w_sum         = {1'b0, w_a} + {1'b0, w_b};
  assign bus.res_carry = r_carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carry <= 1'b0;
    end else if (w_gnt) begin
      r_carry <= w_sum[WIDTH];
    end
  end
`else
  logic [WIDTH-1:0] w_sum;

  assign w_sum = w_a + w_b;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_ptr   <= 1'b0;
      r_data  <= '0;
      r_id    <= 1'b0;
    end else if (w_gnt) begin
      r_state <= FULL;
      r_ptr   <= w_gnt0;
      r_data  <= w_sum[WIDTH-1:0];
      r_id    <= w_gnt1;
    end else if (r_state == FULL && bus.res_ready) begin
      r_state <= EMPTY;
    end
  end

  assign bus.res_valid = (r_state == FULL);
  assign bus.res_data  = r_data;
  assign bus.res_id    = r_id;

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Shares the single 16-bit address adder between two requesters: port 0, the PC-increment path, and port 1, the branch/jump-target path. Each cycle the block arbitrates round-robin between valid requests and performs one modulo-2^16 add. It holds the sum in a one-entry output register with a valid/ready handshake. It sits between the fetch/branch logic and the PC-update stage.

## Interface
Parameters:
- FIXED_PRI, 0, when 1 port 1 always wins and round-robin is disabled
- WIDTH, 16, operand and sum width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous and active-low
- req0_valid  in  1  port 0 request
- req0_a, req0_b  in  WIDTH  port 0 operands
- req0_ready  out  1  port 0 request accepted this cycle
- req1_valid  in  1  port 1 request
- req1_a, req1_b  in  WIDTH  port 1 operands
- req1_ready  out  1  port 1 request accepted this cycle
- res_valid  out  1  output register holds a result
- res_data  out  WIDTH  sum
- res_id  out  1  port that produced res_data
- res_ready  in  1  consumer takes the result this cycle
- res_carry  out  1  carry out of the add (only with ADDER_ARB_CARRY_EN)

## Operation
- States:
  - EMPTY: output register invalid.
  - FULL: output register valid.
- can_accept = (state==EMPTY) | res_ready.
- Grant, computed combinationally:
  - Only one valid request, and can_accept: grant it.
  - Both valid, and can_accept: grant the port selected by the priority pointer `ptr`, or port 1 if FIXED_PRI=1.
  - can_accept=0: no grant.
- reqN_ready = grantN. At most one ready is high per cycle. A request is consumed when valid & ready.
- On a grant:
  - res_data <= a + b of the granted port, truncated to WIDTH (wrap-around, e.g. FFFF+0001 = 0000).
  - res_id <= granted port.
  - state -> FULL.
  - `ptr` <= the other port.
  - If FIXED_PRI=1, `ptr` is unused.
- FULL & res_ready & no grant: state -> EMPTY. res_data and res_id hold their last value.
- FULL & !res_ready: the register holds. No grant is issued, and both readys are low.
- Simultaneous drain and grant in FULL (res_ready=1 and a valid request): the new result replaces the old one in the same edge. State stays FULL. This gives full throughput.
- An ungranted request must be held stable by its requester. The block never drops or reorders a consumed request.
- Reset, asynchronous and valid mid-operation:
  - state=EMPTY, res_valid=0.
  - res_data=0, res_id=0, res_carry=0.
  - ptr=0, so port 0 is favoured first.
  - A pending result is discarded.
  - Readys are forced low while rst_n=0.

## Timing
- Latency: a request accepted at edge N produces res_valid=1 with its sum after edge N, i.e. one cycle.
- Throughput: one add per cycle while res_ready is held high.
- reqN_ready depends combinationally on reqN_valid, the other port's valid, state, ptr and res_ready. It has no combinational path from the operands.
- Outputs res_valid, res_data, res_id and res_carry are registered.
- Starvation bound: with both ports continuously valid and res_ready=1, each port is granted every second cycle when FIXED_PRI=0.

## Configuration
- ADDER_ARB_CARRY_EN defined:
  - The adder is WIDTH+1 bits wide.
  - res_carry is registered alongside res_data and carries the carry-out, e.g. FFFF+0001 gives res_carry=1.
- ADDER_ARB_CARRY_EN undefined:
  - The res_carry port does not exist.
  - The add is WIDTH bits and the carry is discarded.

## Test plan
- Reset with req0_valid=1 and rst_n=0: all readys are 0, res_valid=0 and res_data=0000. After release, the request is granted on the first edge.
- Single request, port 0, a=0010 b=0001, res_ready=1: req0_ready=1 in the same cycle; next cycle res_valid=1, res_data=0011, res_id=0.
- Both ports valid continuously, port 0 a=0100 b=0001, port 1 a=0200 b=0020, res_ready=1: grants alternate 0,1,0,1; res_data alternates 0101 and 0220.
- Backpressure: res_ready=0 with FULL and both requests valid: both readys stay 0 for 5 cycles and res_data is held. Raising res_ready gives a same-cycle grant, and the new result appears next cycle.
- Wrap-around: a=FFFF, b=0002 gives res_data=0001. With ADDER_ARB_CARRY_EN defined, res_carry=1.
- Asynchronous reset asserted mid-cycle while FULL: res_valid drops immediately without waiting for a clock edge, and ptr returns to 0. After reset, the first contested grant goes to port 0.
